// File: rtl/keypad_scanner_4x4_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_4x4_if
//   Key-delivery bus between the 4x4 keypad scanner and the control logic
//   that consumes the key codes.
//
//   Signals:
//     key_code     4-bit key code = row*4 + col
//     key_valid    key available (pulse, or FIFO not empty when the FIFO is
//                  compiled in)
//     key_held     high while the accepted key is still pressed
//     key_rd       pop strobe from the consumer (FIFO build only)
//     key_overrun  sticky flag: a key was dropped
//
//   Modports:
//     master  scanner side (drives the key outputs, reads key_rd)
//     slave   consumer side (reads the key outputs, drives key_rd)
// ---------------------------------------------------------------------------
interface keypad_scanner_4x4_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_rd;
    logic       key_overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output key_overrun,
        input  key_rd
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  key_overrun,
        output key_rd
    );
endinterface

// File: rtl/keypad_scanner_4x4.sv
// ---------------------------------------------------------------------------
// keypad_scanner_4x4
//   Column-scanning reader for a 4x4 active-low membrane keypad. One column
//   is driven low at a time; the rows are synchronised, sampled once per
//   column dwell, debounced for press and release, and the accepted key is
//   delivered as {row, col}.
//
//   Parameters:
//     SCAN_DIV        clocks per column dwell (2 .. 2^20)
//     DEBOUNCE_SCANS  consecutive matching samples to accept press/release
//                     (1 .. 15)
//
//   Ports:
//     clk         system clock
//     reiniciar   synchronous active-high reset
//     linha_in    keypad rows, active-low, asynchronous
//     coluna_out  column drive, active-low, one-cold, registered
//     key_if      key delivery bus (master modport)
//
//   Build option:
//     KEYPAD_FIFO_EN  when defined, accepted keys go into a 4-entry FIFO
//                     popped by key_rd; otherwise key_valid is a one-clock
//                     pulse and key_code holds the last key.
// ---------------------------------------------------------------------------
module keypad_scanner_4x4 #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                        clk,
    input  logic                        reiniciar,
    input  logic [3:0]                  linha_in,
    output logic [3:0]                  coluna_out,
    keypad_scanner_4x4_if.master        key_if
);

    localparam int                CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB_MAX = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_e;

    logic [3:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    state_e           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       rel_q, rel_d;
    logic [3:0]       coluna_q, coluna_d;
    logic             key_held_q, key_held_d;

    logic             tick_s;
    logic             any_low_s;
    logic [1:0]       low_row_s;
    logic             latched_low_s;
    logic             emit_s;
    logic [3:0]       emit_code_s;

    assign tick_s        = (cnt_q == CNT_MAX);
    assign any_low_s     = (sync2_q != 4'hF);
    assign latched_low_s = ~sync2_q[row_q];
    assign emit_code_s   = {row_d, col_d};

    // Lowest-index low row wins when several rows are pressed together.
    always_comb begin
        low_row_s = 2'd3;
        if (!sync2_q[0]) begin
            low_row_s = 2'd0;
        end else if (!sync2_q[1]) begin
            low_row_s = 2'd1;
        end else if (!sync2_q[2]) begin
            low_row_s = 2'd2;
        end else begin
            low_row_s = 2'd3;
        end
    end

    // Dwell divider and registered column drive.
    always_comb begin
        cnt_d = cnt_q;
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // The drive follows idx one clock late, so columns change the clock after a tick.
        coluna_d = ~(4'b0001 << idx_q);
    end

    // Scan / debounce / pressed next-state logic; everything moves only on tick.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        match_d = match_q;
        rel_d   = rel_q;
        emit_s  = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (tick_s && any_low_s) begin
                    row_d   = low_row_s;
                    col_d   = idx_q;
                    match_d = 4'd1;
                    rel_d   = 4'd0;
                    if (DEB_MAX == 4'd1) begin
                        emit_s  = 1'b1;
                        state_d = ST_PRESSED;
                    end else begin
                        state_d = ST_DEBOUNCE;
                    end
                end else if (tick_s) begin
                    idx_d = idx_q + 2'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DEBOUNCE: begin
                if (tick_s && latched_low_s) begin
                    match_d = match_q + 4'd1;
                    if ((match_q + 4'd1) == DEB_MAX) begin
                        emit_s  = 1'b1;
                        rel_d   = 4'd0;
                        state_d = ST_PRESSED;
                    end else begin
                        state_d = ST_DEBOUNCE;
                    end
                end else if (tick_s) begin
                    // Bounce: abandon the candidate and resume scanning at the next column.
                    match_d = 4'd0;
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_PRESSED: begin
                if (tick_s && !latched_low_s) begin
                    if ((rel_q + 4'd1) == DEB_MAX) begin
                        rel_d   = 4'd0;
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SCAN;
                    end else begin
                        rel_d = rel_q + 4'd1;
                    end
                end else if (tick_s) begin
                    rel_d = 4'd0;
                end else begin
                    rel_d = rel_q;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
        key_held_d = (state_d == ST_PRESSED);
    end

    // Synchroniser, divider, column drive and scanner state registers.
    always_ff @(posedge clk) begin
        if (reiniciar) begin
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            state_q    <= ST_SCAN;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            match_q    <= 4'd0;
            rel_q      <= 4'd0;
            coluna_q   <= 4'b1110;
            key_held_q <= 1'b0;
        end else begin
            sync1_q    <= linha_in;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            match_q    <= match_d;
            rel_q      <= rel_d;
            coluna_q   <= coluna_d;
            key_held_q <= key_held_d;
        end
    end

    assign coluna_out      = coluna_q;
    assign key_if.key_held = key_held_q;

`ifdef KEYPAD_FIFO_EN
    logic [3:0] fifo_q [0:3];
    logic [3:0] fifo_d [0:3];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       overrun_q, overrun_d;
    logic       full_s, empty_s, push_s, pop_s;

    assign full_s  = (count_q == 3'd4);
    assign empty_s = (count_q == 3'd0);
    assign pop_s   = key_if.key_rd && !empty_s;
    // A pop in the same clock frees the slot, so emit-while-full still lands.
    assign push_s  = emit_s && (!full_s || pop_s);

    // FIFO pointers, occupancy and overrun flag.
    always_comb begin
        fifo_d = fifo_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = emit_code_s;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (emit_s && full_s && !pop_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // FIFO storage and control registers.
    always_ff @(posedge clk) begin
        if (reiniciar) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 4'd0;
            end
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign key_if.key_code    = fifo_q[rd_ptr_q];
    assign key_if.key_valid   = !empty_s;
    assign key_if.key_overrun = overrun_q;
`else
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       unused_key_rd_s;

    assign unused_key_rd_s = key_if.key_rd;

    // Last-key register and one-clock valid pulse.
    always_comb begin
        if (emit_s) begin
            key_code_d = emit_code_s;
        end else begin
            key_code_d = key_code_q;
        end
        key_valid_d = emit_s;
    end

    // Key output registers.
    always_ff @(posedge clk) begin
        if (reiniciar) begin
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign key_if.key_code    = key_code_q;
    assign key_if.key_valid   = key_valid_q;
    assign key_if.key_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner_4x4
//   Scoreboard bench for keypad_scanner_4x4 (SCAN_DIV=4, DEBOUNCE_SCANS=3).
//   A behavioural keypad pulls rows low for pressed keys whose column is
//   driven. Each press long enough to be accepted pushes its key into a
//   reference queue (bounded at 4 with KEYPAD_FIFO_EN); a monitor pops and
//   compares whenever key_valid is seen.
// ---------------------------------------------------------------------------
module tb_keypad_scanner_4x4;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
`ifdef KEYPAD_FIFO_EN
    localparam int MODEL_DEPTH = 4;
`else
    localparam int MODEL_DEPTH = 1000000;
`endif

    logic        clk = 1'b0;
    logic        reiniciar = 1'b1;
    logic [3:0]  linha_in;
    logic [3:0]  coluna_out;
    logic [15:0] pressed = 16'h0000;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    bit mon_en = 1'b1;
    bit exp_overrun = 1'b0;

    keypad_scanner_4x4_if kif();

    keypad_scanner_4x4 #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk        (clk),
        .reiniciar  (reiniciar),
        .linha_in   (linha_in),
        .coluna_out (coluna_out),
        .key_if     (kif)
    );

    always #5 clk = ~clk;

    // Keypad: key k sits at row k/4, column k%4 and shorts them when pressed.
    always_comb begin
        linha_in = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (pressed[k] && !coluna_out[k % 4]) linha_in[k / 4] = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model of the delivery path: keys queue in order, excess keys are dropped.
    task automatic expect_key(input int k);
        if (exp_q.size() < MODEL_DEPTH) exp_q.push_back(k);
        else exp_overrun = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reiniciar = 1'b1;
        pressed   = 16'h0000;
        tick(2);
        reiniciar = 1'b0;
    endtask

    task automatic press(input int k, input int dur, input bit accepted);
        if (accepted) expect_key(k);
        pressed[k] = 1'b1;
        tick(dur);
        pressed[k] = 1'b0;
        tick(30);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: every presented key is compared with the head of the reference queue.
    always @(negedge clk) begin
        if (reiniciar) begin
            kif.key_rd = 1'b0;
        end else if (kif.key_valid && mon_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_key: got %0d, expected none (t=%0t)", kif.key_code, $time);
            end else begin
                check("key_code", kif.key_code, exp_q.pop_front());
            end
`ifndef KEYPAD_FIFO_EN
            check("held_with_valid", kif.key_held, 1);
`endif
            kif.key_rd = 1'b1;
        end else begin
            kif.key_rd = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [3:0] e;
        int         keys[5] = '{0, 5, 10, 15, 1};

        // Reset values
        tick(2);
        check("rst_coluna", coluna_out, 4'b1110);
        check("rst_valid", kif.key_valid, 0);
        check("rst_held", kif.key_held, 0);
        check("rst_code", kif.key_code, 0);
        check("rst_overrun", kif.key_overrun, 0);
        reiniciar = 1'b0;

        // Column rotation: 4 clocks per column, first change after the first tick
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            e = ~(4'b0001 << (((k - 1) / 4) % 4));
            check("coluna_step", coluna_out, e);
        end

        // Press latency: key 4 in column 0 from reset -> detect tick 4, emit tick 12
        do_reset();
        expect_key(4);
        pressed[4] = 1'b1;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (kif.key_valid) begin n = i; break; end
        end
        check("press_latency", n, 12);
        check("press_held", kif.key_held, 1);
        pressed[4] = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (!kif.key_held) begin n = i; break; end
        end
        check("release_latency", n, 12);
        tick(10);

        // Reset after two matching ticks: no key, outputs back to reset values
        do_reset();
        pressed[8] = 1'b1;
        tick(9);
        reiniciar = 1'b1;
        tick(2);
        reiniciar  = 1'b0;
        pressed[8] = 1'b0;
        check("midrst_coluna", coluna_out, 4'b1110);
        check("midrst_valid", kif.key_valid, 0);
        check("midrst_held", kif.key_held, 0);
        check("midrst_code", kif.key_code, 0);
        tick(40);

        // Clean press of key 9 (row 2, column 1)
        expect_key(9);
        pressed[9] = 1'b1;
        tick(38);
        check("clean_held", kif.key_held, 1);
        tick(2);
        pressed[9] = 1'b0;
        tick(30);
        check("clean_released", kif.key_held, 0);

        // Bounce on key 3 for one tick: column 3 dwells twice, then scanning resumes at 0
        for (int i = 0; i < 40 && coluna_out == 4'b0111; i++) tick(1);
        for (int i = 0; i < 40 && coluna_out != 4'b0111; i++) tick(1);
        pressed[3] = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (i == 4) pressed[3] = 1'b0;
            if (coluna_out != 4'b0111) begin n = i; break; end
        end
        check("bounce_dwell", n, 8);
        check("bounce_next_col", coluna_out, 4'b1110);
        tick(20);
        press(3, 50, 1'b1);

        // Rows 1 and 3 in column 2 -> key 6; key 15 blocked until 6 is released
        expect_key(6);
        pressed[6]  = 1'b1;
        pressed[14] = 1'b1;
        tick(50);
        check("multi_held", kif.key_held, 1);
        pressed[15] = 1'b1;
        tick(40);
        check("rollover_held", kif.key_held, 1);
        expect_key(15);
        pressed[6]  = 1'b0;
        pressed[14] = 1'b0;
        tick(60);
        pressed[15] = 1'b0;
        tick(30);
        wait_empty();

        // Random single presses: short ones (<= 6 clocks) can never see 3 ticks
        for (int it = 0; it < 12; it++) begin
            int k;
            bit lng;
            k   = int'($urandom_range(0, 15));
            lng = 1'($urandom_range(0, 1));
            tick(int'($urandom_range(0, 7)));
            if (lng) press(k, int'($urandom_range(50, 80)), 1'b1);
            else     press(k, int'($urandom_range(1, 6)), 1'b0);
        end
        wait_empty();
        check("final_held", kif.key_held, 0);

`ifdef KEYPAD_FIFO_EN
        // Five unread keys into a 4-entry FIFO
        do_reset();
        mon_en = 1'b0;
        exp_overrun = 1'b0;
        foreach (keys[i]) press(keys[i], 50, 1'b1);
        check("fifo_overrun", kif.key_overrun, int'(exp_overrun));
        check("fifo_head", kif.key_code, exp_q[0]);
        check("fifo_valid", kif.key_valid, 1);
        mon_en = 1'b1;
        wait_empty();
        tick(2);
        check("fifo_empty_valid", kif.key_valid, 0);
        check("fifo_overrun_sticky", kif.key_overrun, 1);
        do_reset();
        check("fifo_overrun_rst", kif.key_overrun, 0);
`else
        check("overrun_tied", kif.key_overrun, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scanner_4x4.md
# keypad_scanner_4x4

Column-scanning reader for a 4x4 membrane keypad used to enter irrigation setpoints. It drives one active-low column at a time and samples the four active-low row inputs. It then debounces the press and delivers a 4-bit key code to the control logic. It is the input-side counterpart of the column-scanned LED matrix driver and runs from the same system clock.

## Interface
- SCAN_DIV, 50000: clocks per column dwell; range 2..2^20.
- DEBOUNCE_SCANS, 4: consecutive matching samples required to accept a press or a release; range 1..15.
- clk  in  1  system clock.
- reiniciar  in  1  reset; one clock, reset is synchronous and active-high.
- linha_in  in  4  keypad rows; active-low, asynchronous, pulled up externally.
- coluna_out  out  4  column drive; active-low, one-cold.
- key_code  out  4  key code = row*4 + col.
- key_valid  out  1  key available (meaning depends on configuration).
- key_held  out  1  high while an accepted key is still pressed.
- key_rd  in  1  pop strobe; used only with the FIFO compiled in.
- key_overrun  out  1  sticky: a key was dropped.

## Operation
- Synchronizer: linha_in passes through two flops before any use.
- Divider:
  - Counter 0..SCAN_DIV-1; `tick` is asserted when the count equals SCAN_DIV-1.
  - Rows are sampled only on tick.
- Column index 0..3; coluna_out = ~(1 << idx). The index advances on tick only in SCAN, wrapping 3->0.
- SCAN:
  - On tick, if any synchronized row is low, latch row (lowest-index low row wins) and col = idx.
  - Set match = 1, freeze idx, go to DEBOUNCE.
  - If DEBOUNCE_SCANS = 1, go directly to PRESSED and emit the key.
- DEBOUNCE:
  - On tick, if the latched row is still low, match++. When match reaches DEBOUNCE_SCANS, emit the key and go to PRESSED.
  - If the latched row is high on tick, go to SCAN, and idx advances on that same tick.
  - Other rows going low are ignored.
- PRESSED:
  - key_held = 1; idx stays frozen.
  - Release counter counts consecutive ticks with the latched row high. Any low sample clears it.
  - At DEBOUNCE_SCANS, go to SCAN and advance idx.
  - No new key is emitted while in PRESSED, so there is no auto-repeat and rollover keys are ignored.
- Emit: key_code <= {row[1:0], col[1:0]}.
- Reset mid-operation: state returns to SCAN and all counters and any FIFO contents are cleared on the next edge.
- Reset values:
  - coluna_out = 4'b1110, idx = 0.
  - key_code = 0, key_valid = 0, key_held = 0, key_overrun = 0.
  - State = SCAN.

## Timing
- Row-to-sample delay: 2 clocks (synchronizer). A row change is visible on a tick only if it occurs at least 2 clocks before that tick.
- Press latency: emit happens on the tick that is (DEBOUNCE_SCANS-1) ticks after the detect tick. key_valid and key_code update on the clock after that emit tick.
- key_held rises together with key_valid.
- key_held falls on the clock after the DEBOUNCE_SCANS-th consecutive release tick.
- coluna_out changes on the clock after a tick, because it is registered from idx.

## Configuration
- KEYPAD_FIFO_EN defined:
  - 4-entry FIFO of key codes.
  - key_valid = FIFO not empty; key_code = head entry (combinational from the FIFO).
  - key_rd with key_valid pops one entry next clock; key_rd while empty is ignored.
  - Emit while full drops the new key and sets key_overrun. key_overrun clears only on reiniciar.
  - Simultaneous emit and pop while full: both take effect and no overrun is raised.
- KEYPAD_FIFO_EN undefined:
  - key_valid is a one-clock pulse per emitted key.
  - key_code holds the last emitted key until the next emit.
  - key_rd is ignored and key_overrun is tied 0.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3.
- Reset: hold reiniciar 2 clocks -> coluna_out=1110, key_valid=0, key_held=0, key_code=0. Release -> coluna_out steps 1110->1101->1011->0111->1110 every 4 clocks.
- Clean press: row 2 low while column 1 is active, held for 40 clocks -> exactly one key_valid with key_code=9 and key_held=1. Release -> key_held=0 after 3 high ticks.
- Bounce: row 0 low for 1 tick in column 3, then high -> no key_valid, and scanning resumes at column 0. A later stable press on row 0, column 3 -> key_code=3.
- Two rows low in the same column: rows 1 and 3 low in column 2 -> key_code=6 (lowest row wins). While key 6 is held, pressing key 15 -> no new key until key 6 is released.
- Reset mid-debounce: assert reiniciar after 2 matching ticks -> no key_valid, and outputs return to their reset values.
- FIFO (KEYPAD_FIFO_EN): five presses (keys 0, 5, 10, 15, 1) with no key_rd -> key_overrun=1 and key_code=0. Four pops return 0, 5, 10, 15; key_valid=0 after the fourth pop.
